// File: rtl/fb_window_mapper.sv
// fb_window_mapper: maps the raster onto a framebuffer window and builds read addresses.
// In: clk, rstn, col/row, hsync_in/vsync_in, window config, fb_rd_data.
// Out: fb_rd_addr/fb_rd_en, hsync_out/vsync_out, rgb_out.
module fb_window_mapper #(
  parameter int FB_W    = 640,
  parameter int FB_H    = 480,
  parameter int DISP_W  = 800,
  parameter int DISP_H  = 600,
  parameter int H_TOTAL = 1056,
  parameter int V_TOTAL = 628,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 12,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [10:0]       col,
  input  logic [9:0]        row,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [10:0]       x_off,
  input  logic [9:0]        y_off,
  input  logic              scale2,
  input  logic              mirror,
  input  logic [DATA_W-1:0] border_rgb,
  output logic [ADDR_W-1:0] fb_rd_addr,
  output logic              fb_rd_en,
  input  logic [DATA_W-1:0] fb_rd_data,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [DATA_W-1:0] rgb_out
);

  localparam int XCW = $clog2(FB_W + 1);
  localparam int FRW = $clog2(FB_H + 1);

  localparam logic [10:0] C_HLAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  C_VLAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] C_DW    = 11'(DISP_W);
  localparam logic [9:0]  C_DH    = 10'(DISP_H);
  localparam logic [ADDR_W-1:0] C_FBW_A = ADDR_W'(FB_W);
  localparam logic [XCW-1:0]    C_XMAX  = XCW'(FB_W - 1);
  localparam logic [FRW-1:0]    C_FBH   = FRW'(FB_H);

  logic [10:0]       r_x_off;
  logic [9:0]        r_y_off;
  logic              r_scale2;
  logic              r_mirror;
  logic [DATA_W-1:0] r_border;

  logic [ADDR_W-1:0] r_line_base;
  logic              r_ysub;
  logic [FRW-1:0]    r_fb_row;
  logic [XCW-1:0]    r_xcnt;
  logic              r_xsub;

  logic [ADDR_W-1:0] r_addr;
  logic              r_en;
  logic              r_vis1;
  logic              r_hs1;
  logic              r_vs1;
  // flags per stage: {in-window, visible, hsync, vsync}
  logic [3:0]        r_pipe [RD_LAT];
  logic [DATA_W-1:0] r_rgb;
  logic              r_hs_o;
  logic              r_vs_o;

  logic              w_frame_end;
  logic              w_line_end;
  logic [11:0]       w_ww;
  logic [10:0]       w_wh;
  logic [11:0]       w_x_end;
  logic [10:0]       w_y_end;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_vis;
  logic              w_in;
  logic [XCW-1:0]    w_acol;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_tail;

  assign w_line_end  = (col == C_HLAST);
  assign w_frame_end = w_line_end && (row == C_VLAST);

  // Bounds carry one extra bit so a far-right/bottom window never wraps.
  assign w_ww    = r_scale2 ? 12'(2 * FB_W) : 12'(FB_W);
  assign w_wh    = r_scale2 ? 11'(2 * FB_H) : 11'(FB_H);
  assign w_x_end = {1'b0, r_x_off} + w_ww;
  assign w_y_end = {1'b0, r_y_off} + w_wh;
  assign w_in_x  = (col >= r_x_off) && ({1'b0, col} < w_x_end);
  assign w_in_y  = (row >= r_y_off) && ({1'b0, row} < w_y_end);
  assign w_vis   = (col < C_DW) && (row < C_DH);
  assign w_in    = w_in_x && w_in_y && w_vis;

  assign w_acol = r_mirror ? (C_XMAX - r_xcnt) : r_xcnt;
  assign w_addr = r_line_base + ADDR_W'(w_acol);

  // Config only moves at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_x_off  <= 11'd80;
      r_y_off  <= 10'd60;
      r_scale2 <= 1'b0;
      r_mirror <= 1'b0;
      r_border <= '1;
    end else if (w_frame_end) begin
      r_x_off  <= x_off;
      r_y_off  <= y_off;
      r_scale2 <= scale2;
      r_mirror <= mirror;
      r_border <= border_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || w_frame_end) begin
      r_line_base <= '0;
      r_ysub      <= 1'b0;
      r_fb_row    <= '0;
    end else if (w_line_end && w_in_y) begin
      if (r_scale2)
        r_ysub <= ~r_ysub;
      if ((!r_scale2 || r_ysub) && (r_fb_row != C_FBH)) begin
        r_line_base <= r_line_base + C_FBW_A;
        r_fb_row    <= r_fb_row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || w_line_end) begin
      r_xcnt <= '0;
      r_xsub <= 1'b0;
    end else if (w_in) begin
      if (!r_scale2 || r_xsub)
        r_xcnt <= r_xcnt + 1'b1;
      if (r_scale2)
        r_xsub <= ~r_xsub;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr <= '0;
      r_en   <= 1'b0;
      r_vis1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
    end else begin
      r_en   <= w_in;
      r_vis1 <= w_vis;
      r_hs1  <= hsync_in;
      r_vs1  <= vsync_in;
      if (w_in)
        r_addr <= w_addr;
    end
  end

  // Flags ride alongside the memory read so they meet the returned data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {r_en, r_vis1, r_hs1, r_vs1};
      for (int i = 1; i < RD_LAT; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail = r_pipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rgb  <= '0;
      r_hs_o <= 1'b0;
      r_vs_o <= 1'b0;
    end else begin
      r_hs_o <= w_tail[1];
      r_vs_o <= w_tail[0];
      if (w_tail[3])
        r_rgb <= fb_rd_data;
      else if (w_tail[2])
        r_rgb <= r_border;
      else
        r_rgb <= '0;
    end
  end

  assign fb_rd_addr = r_addr;
  assign fb_rd_en   = r_en;
  assign hsync_out  = r_hs_o;
  assign vsync_out  = r_vs_o;
  assign rgb_out    = r_rgb;

endmodule
